multi_delay: RTL and testbench

MULTI_DELAY -- requirements
Module: multi_delay

---
 rtl/multi_delay_pkg.sv | 23 ++
 rtl/multi_delay_chan.sv | 81 ++++++++
 rtl/multi_delay.sv | 51 +++++
 tb/tb_multi_delay.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_delay_pkg.sv
// Shared constants, channel-index width helper and per-channel state record for multi_delay.
// Optional feature macro: MULTI_DELAY_ONESHOT_EN adds the mode and done fields to the state record.
// cnt/period are held at CBITS_MAX width; channels only ever load zero-extended CBITS values.
package multi_delay_pkg;

    localparam int N_DEF_DEFAULT = 10000;
    localparam int CBITS_MAX     = 32;

    // Width of a channel index; a single channel still gets a 1-bit select.
    function automatic int chw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [CBITS_MAX-1:0] cnt;
        logic [CBITS_MAX-1:0] period;
`ifdef MULTI_DELAY_ONESHOT_EN
        logic                 mode;   // 1 = one-shot
        logic                 done;   // one-shot has fired, hold until en drops
`endif
    } chan_state_t;

endpackage

// File: rtl/multi_delay_chan.sv
// One delay channel: counts enabled cycles up to its period and flags expiry.
// Latency: sig/err/flg are zero-latency compares of cnt against period; state updates on posedge clk.
// No backpressure: en gates counting, a config write restarts the channel immediately.
// Ports: clk, rst (sync active-low), en, we (decoded write), wr_period, wr_oneshot -> sig, err, flg, busy.
// Macro MULTI_DELAY_ONESHOT_EN enables the one-shot mode/done storage.
module multi_delay_chan
    import multi_delay_pkg::*;
#(
    parameter int CBITS = 14,
    parameter int N_DEF = N_DEF_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [CBITS-1:0] wr_period,
    input  logic             wr_oneshot,
    output logic             sig,
    output logic             err,
    output logic             flg,
    output logic             busy
);

    localparam logic [CBITS_MAX-1:0] PER_RST = CBITS_MAX'(N_DEF);

    chan_state_t st;

    // Bits above CBITS are only ever loaded with zero, so these full-width
    // compares reduce to CBITS-wide compares after constant propagation.
    assign sig = (st.cnt >= st.period);
    assign err = (st.cnt >  st.period);
    assign flg = (st.cnt <  st.period);

`ifdef MULTI_DELAY_ONESHOT_EN
    assign busy = en & ~st.done;
`else
    assign busy = en;
    logic unused_oneshot;
    assign unused_oneshot = wr_oneshot;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            st.cnt    <= '0;
            st.period <= PER_RST;
`ifdef MULTI_DELAY_ONESHOT_EN
            st.mode   <= 1'b0;
            st.done   <= 1'b0;
`endif
        end else if (we) begin
            st.cnt    <= '0;
            // A zero period would leave sig stuck high; clamp to 1.
            st.period <= (wr_period == '0) ? CBITS_MAX'(1) : CBITS_MAX'(wr_period);
`ifdef MULTI_DELAY_ONESHOT_EN
            st.mode   <= wr_oneshot;
            st.done   <= 1'b0;
`endif
        end else if (!en) begin
            st.cnt    <= '0;
`ifdef MULTI_DELAY_ONESHOT_EN
            st.done   <= 1'b0;
`endif
`ifdef MULTI_DELAY_ONESHOT_EN
        end else if (st.done) begin
            st.cnt    <= '0;
`endif
        end else if (flg) begin
            // cnt < period <= 2^CBITS-1, so the CBITS-wide increment cannot wrap.
            st.cnt    <= CBITS_MAX'(st.cnt[CBITS-1:0] + CBITS'(1));
        end else begin
            st.cnt    <= '0;
`ifdef MULTI_DELAY_ONESHOT_EN
            st.done   <= st.mode;
`endif
        end
    end

    a_sig_pulse: assert property (@(posedge clk) disable iff (!rst) sig |=> !sig);
    a_no_err:    assert property (@(posedge clk) disable iff (!rst) !err);

endmodule

// File: rtl/multi_delay.sv
// Bank of NCH independent delay channels with a shared single-cycle period/mode write port.
// Latency: outputs are combinational from channel state; a write takes effect on the next posedge.
// No backpressure: writes addressed to cfg_ch >= NCH are dropped without any state change.
// Ports: clk, rst (sync active-low), en[NCH], cfg_we/cfg_ch/cfg_period/cfg_oneshot -> sig, err, flg, busy [NCH].
// Macro MULTI_DELAY_ONESHOT_EN enables one-shot mode; otherwise all channels are periodic.
module multi_delay
    import multi_delay_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CBITS = 14,
    parameter int N_DEF = N_DEF_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic                 cfg_we,
    input  logic [chw(NCH)-1:0]  cfg_ch,
    input  logic [CBITS-1:0]     cfg_period,
    input  logic                 cfg_oneshot,
    output logic [NCH-1:0]       sig,
    output logic [NCH-1:0]       err,
    output logic [NCH-1:0]       flg,
    output logic [NCH-1:0]       busy
);

    localparam int CHW = chw(NCH);

    logic [NCH-1:0] ch_we;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // Out-of-range channel numbers match no index and so write nothing.
        assign ch_we[i] = cfg_we && (cfg_ch == CHW'(i));

        multi_delay_chan #(
            .CBITS (CBITS),
            .N_DEF (N_DEF)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (en[i]),
            .we         (ch_we[i]),
            .wr_period  (cfg_period),
            .wr_oneshot (cfg_oneshot),
            .sig        (sig[i]),
            .err        (err[i]),
            .flg        (flg[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_delay.sv
// Scoreboard bench for multi_delay: a 2-channel and a 3-channel instance share stimulus.
// Expected outputs come from a model tracking consecutive enabled cycles per channel.
// A monitor pops one expectation per cycle and compares all outputs of both instances.
module tb_multi_delay;

    localparam int CB   = 4;
    localparam int NDEF = 5;
`ifdef MULTI_DELAY_ONESHOT_EN
    localparam bit OS_EN = 1'b1;
`else
    localparam bit OS_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] en_v;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [3:0] cfg_period;
    logic       cfg_oneshot;
    logic [1:0] sig2, err2, flg2, busy2;
    logic [2:0] sig3, err3, flg3, busy3;

    multi_delay #(.NCH(2), .CBITS(CB), .N_DEF(NDEF)) dut (
        .clk(clk), .rst(rst), .en(en_v[1:0]), .cfg_we(cfg_we), .cfg_ch(cfg_ch[0]),
        .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
        .sig(sig2), .err(err2), .flg(flg2), .busy(busy2));

    multi_delay #(.NCH(3), .CBITS(CB), .N_DEF(NDEF)) dut3 (
        .clk(clk), .rst(rst), .en(en_v), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
        .sig(sig3), .err(err3), .flg(flg3), .busy(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: k = consecutive enabled posedges since the last restart of the channel.
    int  k   [2][3];
    int  per [2][3];
    bit  os  [2][3];
    bit  mvalid = 1'b0;
    int  checks = 0;
    int  errors = 0;
    int  cycle  = 0;
    logic [23:0] expq[$];

    function automatic int nch(input int u);
        return (u == 0) ? 2 : 3;
    endfunction

    // Returns {sig, err, flg, busy}, 3 bits each.
    function automatic logic [11:0] model_out(input int u, input logic [2:0] e);
        logic [2:0] s, er, f, b;
        int c;
        s = '0; er = '0; f = '0; b = '0;
        for (int i = 0; i < nch(u); i++) begin
            if (os[u][i]) c = (k[u][i] <= per[u][i]) ? k[u][i] : 0;
            else          c = k[u][i] % (per[u][i] + 1);
            s[i]  = (c == per[u][i]);
            er[i] = 1'b0;
            f[i]  = (c < per[u][i]);
            b[i]  = e[i] && !(os[u][i] && (k[u][i] > per[u][i]));
        end
        return {s, er, f, b};
    endfunction

    task automatic model_step(input logic r, input logic [2:0] e, input logic w,
                              input logic [1:0] ch, input logic [3:0] p, input logic o);
        int tgt;
        for (int u = 0; u < 2; u++) begin
            tgt = (u == 0) ? int'(ch[0]) : int'(ch);
            for (int i = 0; i < nch(u); i++) begin
                if (!r) begin
                    k[u][i] = 0; per[u][i] = NDEF; os[u][i] = 1'b0;
                end else if (w && tgt == i) begin
                    k[u][i] = 0; per[u][i] = (p == 0) ? 1 : int'(p); os[u][i] = OS_EN && o;
                end else if (!e[i]) begin
                    k[u][i] = 0;
                end else begin
                    k[u][i] = k[u][i] + 1;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs at the negedge, queue expected outputs, step the model.
    task automatic cyc(input logic r, input logic [2:0] e, input logic w,
                       input logic [1:0] ch, input logic [3:0] p, input logic o);
        rst = r; en_v = e; cfg_we = w; cfg_ch = ch; cfg_period = p; cfg_oneshot = o;
        if (mvalid) expq.push_back({model_out(0, e), model_out(1, e)});
        @(posedge clk);
        model_step(r, e, w, ch, p, o);
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] e, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, e, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] e, input logic [1:0] ch, input logic [3:0] p, input logic o);
        cyc(1'b1, e, 1'b1, ch, p, o);
    endtask

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle %0d %s: got %b expected %b", cycle, nm, act, exp);
        end
    endtask

    // Monitor: compares every cycle for which an expectation was queued.
    initial begin
        logic [23:0] x;
        forever begin
            @(negedge clk);
            #1;
            cycle++;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                chk("u0 sig",  {1'b0, sig2},  x[23:21]);
                chk("u0 err",  {1'b0, err2},  x[20:18]);
                chk("u0 flg",  {1'b0, flg2},  x[17:15]);
                chk("u0 busy", {1'b0, busy2}, x[14:12]);
                chk("u1 sig",  sig3,  x[11:9]);
                chk("u1 err",  err3,  x[8:6]);
                chk("u1 flg",  flg3,  x[5:3]);
                chk("u1 busy", busy3, x[2:0]);
            end
        end
    end

    initial begin
        logic [2:0] e;
        logic       r, w, o;
        logic [1:0] ch;
        logic [3:0] p;
        int         wait_n;

        rst = 1'b0; en_v = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;
        @(negedge clk);
        cyc(1'b0, 3'b000, 1'b0, 2'd0, 4'd0, 1'b0);
        mvalid = 1'b1;

        // Post-reset idle state, then ch0 counting with the default period.
        run(3'b000, 2);
        run(3'b001, 12);
        run(3'b000, 1);

        // Maximum period on ch1: no wrap past 15.
        wr(3'b000, 2'd1, 4'd15, 1'b0);
        run(3'b010, 40);

        // One-shot on ch0, then re-arm by dropping en for a cycle.
        wr(3'b000, 2'd0, 4'd3, 1'b1);
        run(3'b001, 10);
        run(3'b000, 1);
        run(3'b001, 6);

        // Mid-count period write on ch0.
        wr(3'b000, 2'd0, 4'd5, 1'b0);
        run(3'b001, 4);
        wr(3'b001, 2'd0, 4'd2, 1'b0);
        run(3'b001, 6);

        // Period 0 clamps to 1; writes to ch 2 and 3 (3 is out of range for the 3-channel unit).
        wr(3'b001, 2'd0, 4'd0, 1'b0);
        run(3'b001, 8);
        run(3'b111, 3);
        wr(3'b111, 2'd2, 4'd7, 1'b0);
        run(3'b111, 4);
        wr(3'b111, 2'd3, 4'd2, 1'b0);
        run(3'b111, 8);

        // Reset in the middle of a count.
        run(3'b111, 3);
        cyc(1'b0, 3'b111, 1'b1, 2'd1, 4'd9, 1'b1);
        run(3'b111, 14);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            w  = ($urandom_range(0, 7) == 0);
            ch = 2'($urandom_range(0, 3));
            p  = 4'($urandom_range(0, 15));
            o  = 1'($urandom_range(0, 1));
            for (int b = 0; b < 3; b++) e[b] = ($urandom_range(0, 7) != 0);
            cyc(r, e, w, ch, p, o);
        end
        run(3'b000, 2);

        wait_n = 0;
        while (expq.size() > 0 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
